// File: rtl/b11p_modscrambler.sv
// b11p_modscrambler: modular scrambler benchmark core.
// Samples a W-bit word while the hold strobe is low, classifies it and runs
// a multi-cycle datapath (scale, add/subtract, iterative modular reduction,
// offset correction) before presenting a W-bit result on a valid/ready port.
// Optional build macro: B11P_ITER_LIMIT_EN adds a bounded reduction loop
// (parameter MAX_ITER) and a sticky err output.

module b11p_modscrambler #(
  parameter int W    = 6,
  parameter int MOD  = 26,
  parameter int CMAX = 25,
  parameter int K0   = 21,
  parameter int K1   = 42,
  parameter int K2   = 7,
  parameter int K3   = 28
`ifdef B11P_ITER_LIMIT_EN
  ,
  parameter int MAX_ITER = 16
`endif
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] x_in,
  input  logic         stbi,
  input  logic         out_ready,
  output logic [W-1:0] x_out,
  output logic         x_valid,
  output logic         busy
`ifdef B11P_ITER_LIMIT_EN
  ,
  output logic         err
`endif
);

  // Accumulator carries three guard bits; its MSB is the sign bit.
  localparam int AW = W + 3;

  // All constants are folded into accumulator width (silent truncation).
  localparam logic [AW-1:0] MOD_A    = AW'(MOD);
  localparam logic [AW-1:0] K0_A     = AW'(K0);
  localparam logic [AW-1:0] K1_A     = AW'(K1);
  localparam logic [AW-1:0] K2_A     = AW'(K2);
  localparam logic [AW-1:0] K3_A     = AW'(K3);
  localparam logic [AW-1:0] RSOT_LIM = AW'((1 << W) - 1);
  localparam logic [W-1:0]  CMAX_W   = W'(CMAX);
  localparam logic [W-1:0]  ONES_W   = {W{1'b1}};

`ifdef B11P_ITER_LIMIT_EN
  localparam logic [4:0]    ITER_LIM = 5'(MAX_ITER);
`endif

  typedef enum logic [3:0] {
    ST_RESET   = 4'd0,
    ST_DATAIN  = 4'd1,
    ST_SPAZIO  = 4'd2,
    ST_MUL     = 4'd3,
    ST_SOMMA   = 4'd4,
    ST_RSUM    = 4'd5,
    ST_RSOT    = 4'd6,
    ST_COMPL   = 4'd7,
    ST_DATAOUT = 4'd8
  } state_t;

  state_t        state_reg,   state_next;
  logic [W-1:0]  r_in_reg,    r_in_next;
  logic [W-1:0]  cont_reg,    cont_next;
  logic [AW-1:0] acc_reg,     acc_next;
  logic [W-1:0]  x_out_reg,   x_out_next;
  logic          x_valid_reg, x_valid_next;

`ifdef B11P_ITER_LIMIT_EN
  logic [4:0]    iter_reg,    iter_next;
  logic          err_reg,     err_next;
`endif

  // Convenience views of the datapath registers.
  logic [AW-1:0] r_ext;
  logic          acc_sign;
  logic [W-1:0]  acc_low;
  logic [W-1:0]  acc_low_neg;

  assign r_ext       = {3'b000, r_in_reg};
  assign acc_sign    = acc_reg[AW-1];
  assign acc_low     = acc_reg[W-1:0];
  assign acc_low_neg = ~acc_low + 1'b1;

  // Register bank: synchronous reset wins over everything, including a
  // pending result or an in-flight reduction.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= ST_RESET;
      r_in_reg    <= '0;
      cont_reg    <= '0;
      acc_reg     <= '0;
      x_out_reg   <= '0;
      x_valid_reg <= 1'b0;
`ifdef B11P_ITER_LIMIT_EN
      iter_reg    <= '0;
      err_reg     <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      r_in_reg    <= r_in_next;
      cont_reg    <= cont_next;
      acc_reg     <= acc_next;
      x_out_reg   <= x_out_next;
      x_valid_reg <= x_valid_next;
`ifdef B11P_ITER_LIMIT_EN
      iter_reg    <= iter_next;
      err_reg     <= err_next;
`endif
    end
  end

  // Next-state and datapath update for every FSM state.
  always_comb begin
    state_next = state_reg;
    r_in_next  = r_in_reg;
    cont_next  = cont_reg;
    acc_next   = acc_reg;
    x_out_next = x_out_reg;
    // A consumed result drops valid unless a new result overrides below.
    x_valid_next = out_ready ? 1'b0 : x_valid_reg;
`ifdef B11P_ITER_LIMIT_EN
    iter_next = iter_reg;
    err_next  = err_reg;
`endif

    case (state_reg)
      ST_RESET: begin
        cont_next  = '0;
        r_in_next  = x_in;
        x_out_next = '0;
        // x_out has just been zeroed, so it must not be offered as valid.
        x_valid_next = 1'b0;
        state_next = ST_DATAIN;
      end

      ST_DATAIN: begin
        r_in_next  = x_in;
        state_next = stbi ? ST_DATAIN : ST_SPAZIO;
      end

      ST_SPAZIO: begin
        if (r_in_reg == '0 || r_in_reg == ONES_W) begin
          // Extreme words bypass the arithmetic and bump the counter.
          cont_next  = (cont_reg < CMAX_W) ? cont_reg + 1'b1 : '0;
          acc_next   = r_ext;
          state_next = ST_DATAOUT;
        end else if (r_ext <= MOD_A) begin
          state_next = ST_MUL;
        end else begin
          // Out-of-range word: drop it silently.
          state_next = ST_DATAIN;
        end
      end

      ST_MUL: begin
        acc_next   = r_in_reg[0] ? ({3'b000, cont_reg} << 1) : {3'b000, cont_reg};
        state_next = ST_SOMMA;
      end

      ST_SOMMA: begin
`ifdef B11P_ITER_LIMIT_EN
        iter_next = '0;
`endif
        if (r_in_reg[1]) begin
          acc_next   = r_ext + acc_reg;
          state_next = ST_RSUM;
        end else begin
          acc_next   = r_ext - acc_reg;
          state_next = ST_RSOT;
        end
      end

      ST_RSUM: begin
        if (!acc_sign && acc_reg > MOD_A) begin
          acc_next = acc_reg - MOD_A;
`ifdef B11P_ITER_LIMIT_EN
          iter_next = iter_reg + 5'd1;
          if (iter_reg + 5'd1 >= ITER_LIM) begin
            err_next   = 1'b1;
            state_next = ST_COMPL;
          end
`endif
        end else begin
          state_next = ST_COMPL;
        end
      end

      ST_RSOT: begin
        if (!acc_sign && acc_reg > RSOT_LIM) begin
          acc_next = acc_reg + MOD_A;
`ifdef B11P_ITER_LIMIT_EN
          iter_next = iter_reg + 5'd1;
          if (iter_reg + 5'd1 >= ITER_LIM) begin
            err_next   = 1'b1;
            state_next = ST_COMPL;
          end
`endif
        end else begin
          state_next = ST_COMPL;
        end
      end

      ST_COMPL: begin
        case (r_in_reg[3:2])
          2'd0:    acc_next = acc_reg - K0_A;
          2'd1:    acc_next = acc_reg - K1_A;
          2'd2:    acc_next = acc_reg + K2_A;
          default: acc_next = acc_reg + K3_A;
        endcase
        state_next = ST_DATAOUT;
      end

      ST_DATAOUT: begin
        if (x_valid_reg && !out_ready) begin
          // Previous result not yet taken: hold everything.
          x_valid_next = 1'b1;
          state_next   = ST_DATAOUT;
        end else begin
          x_out_next   = acc_sign ? acc_low_neg : acc_low;
          x_valid_next = 1'b1;
          state_next   = ST_DATAIN;
        end
      end

      default: begin
        state_next = ST_RESET;
      end
    endcase
  end

  assign x_out   = x_out_reg;
  assign x_valid = x_valid_reg;
  assign busy    = (state_reg != ST_DATAIN);
`ifdef B11P_ITER_LIMIT_EN
  assign err     = err_reg;
`endif

endmodule
